// File: rtl/flag_crossing_arbiter.sv
// ---------------------------------------------------------------------------
// flag_crossing_arbiter
//
// Shares one flag/ack clock-domain-crossing channel between N_REQ
// single-cycle request sources in the BUS_CLK domain.
//
// Requests are latched as pending and granted round-robin. Every grant issues
// exactly one FLAG_OUT pulse and then follows the crossing's BUSY handshake.
// Completion and timeouts are reported.
//
// Handshake with the crossing:
//   1. A grant drives FLAG_OUT high for exactly one cycle.
//   2. The crossing answers by raising BUSY_IN.
//   3. It drops BUSY_IN when the far side has acknowledged.
//   A new flag is only issued while BUSY_IN is sampled low.
//
// Optional feature (macro FLAG_ARB_LOST_CNT_EN):
//   Adds LOST_CNT, a saturating 8-bit count of requests merged into a pending
//   bit that was already set. ERR_CLR also clears it.
//
// Ports:
//   BUS_CLK    clock (same as the crossing's CLK_A)
//   BUS_RST    asynchronous, active-high reset
//   REQ_IN     one-cycle request pulses, one bit per source
//   ENABLE     0 blocks new grants; requests are still latched
//   BUSY_IN    BUSY from the crossing
//   ERR_CLR    clears ERROR (and LOST_CNT when present)
//   FLAG_OUT   one-cycle flag to the crossing
//   GRANT_ID   source of the transfer in flight, valid while BUSY_OUT=1
//   PENDING    latched, not-yet-granted requests
//   BUSY_OUT   high in every state except IDLE
//   DONE       one-cycle pulse on acknowledged transfer
//   DONE_ID    source of the completed transfer, valid with DONE
//   ERROR      sticky error flag (handshake timeout)
//   LOST_CNT   merged-request count (only with FLAG_ARB_LOST_CNT_EN)
//   DBG_STATE  current FSM state (0 idle, 1 wait-rise, 2 wait-fall)
// ---------------------------------------------------------------------------
module flag_crossing_arbiter #(
    parameter int N_REQ    = 4,
    parameter int ID_WIDTH = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic                BUS_CLK,
    input  logic                BUS_RST,
    input  logic [N_REQ-1:0]    REQ_IN,
    input  logic                ENABLE,
    input  logic                BUSY_IN,
    input  logic                ERR_CLR,
    output logic                FLAG_OUT,
    output logic [ID_WIDTH-1:0] GRANT_ID,
    output logic [N_REQ-1:0]    PENDING,
    output logic                BUSY_OUT,
    output logic                DONE,
    output logic [ID_WIDTH-1:0] DONE_ID,
    output logic                ERROR,
`ifdef FLAG_ARB_LOST_CNT_EN
    output logic [7:0]          LOST_CNT,
`endif
    output logic [1:0]          DBG_STATE
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_WAIT_FALL = 2'd2
    } state_t;

    localparam logic [ID_WIDTH-1:0] LAST_IDX = ID_WIDTH'(N_REQ - 1);
    localparam logic [ID_WIDTH-1:0] ONE_ID   = ID_WIDTH'(1);
    localparam logic [N_REQ-1:0]    ONE_REQ  = N_REQ'(1);
    localparam logic [15:0]         TIMEOUT_CNT = 16'(TIMEOUT);

    state_t              state_q, state_d;
    logic [N_REQ-1:0]    pending_q, pending_d;
    logic [ID_WIDTH-1:0] last_grant_q, last_grant_d;
    logic                flag_out_q, flag_out_d;
    logic [ID_WIDTH-1:0] grant_id_q, grant_id_d;
    logic                busy_out_q, busy_out_d;
    logic                done_q, done_d;
    logic [ID_WIDTH-1:0] done_id_q, done_id_d;
    logic                error_q, error_d;
    logic                rise_cnt_q, rise_cnt_d;
    logic [15:0]         fall_cnt_q, fall_cnt_d;

    // Round-robin search
    logic [ID_WIDTH-1:0]  start_idx;
    logic [2*N_REQ-1:0]   pend_dbl;
    logic                 win_found;
    int                   win_off;
    int                   win_pos;
    logic [ID_WIDTH-1:0]  win_id;

    logic                 grant_fire;
    logic                 err_set;
    logic [15:0]          fall_next;
    logic [N_REQ-1:0]     grant_mask;

    // Search starts one past the last grant. The pending vector is rotated so
    // that the start index lands on bit 0. The first set bit is then the winner.
    always_comb begin
        start_idx = (last_grant_q == LAST_IDX) ? '0 : last_grant_q + ONE_ID;
        pend_dbl  = {pending_q, pending_q} >> start_idx;
        win_found = 1'b0;
        win_off   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!win_found && pend_dbl[k]) begin
                win_found = 1'b1;
                win_off   = k;
            end
        end
        win_pos = int'(start_idx) + win_off;
        if (win_pos >= N_REQ) begin
            win_pos = win_pos - N_REQ;
        end
        win_id = ID_WIDTH'(win_pos);
    end

    always_comb begin
        state_d      = state_q;
        flag_out_d   = 1'b0;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        done_d       = 1'b0;
        done_id_d    = done_id_q;
        rise_cnt_d   = rise_cnt_q;
        fall_cnt_d   = fall_cnt_q;
        grant_fire   = 1'b0;
        err_set      = 1'b0;
        fall_next    = fall_cnt_q + 16'd1;

        case (state_q)
            ST_IDLE: begin
                if (ENABLE && win_found && !BUSY_IN) begin
                    grant_fire   = 1'b1;
                    flag_out_d   = 1'b1;
                    grant_id_d   = win_id;
                    last_grant_d = win_id;
                    rise_cnt_d   = 1'b0;
                    state_d      = ST_WAIT_RISE;
                end
            end
            ST_WAIT_RISE: begin
                // Give the crossing two edges to raise BUSY.
                if (BUSY_IN) begin
                    fall_cnt_d = '0;
                    state_d    = ST_WAIT_FALL;
                end else if (rise_cnt_q) begin
                    err_set = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    rise_cnt_d = 1'b1;
                end
            end
            ST_WAIT_FALL: begin
                // fall_next is the number of cycles spent here including this edge.
                if (!BUSY_IN) begin
                    done_d    = 1'b1;
                    done_id_d = grant_id_q;
                    state_d   = ST_IDLE;
                end else if (fall_next == TIMEOUT_CNT) begin
                    err_set = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    fall_cnt_d = fall_next;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A set on the same edge as ERR_CLR wins.
        if (err_set) begin
            error_d = 1'b1;
        end else if (ERR_CLR) begin
            error_d = 1'b0;
        end else begin
            error_d = error_q;
        end

        busy_out_d = (state_d != ST_IDLE);

        // Clear the granted bit first. A request on the same edge then sets it
        // again as a fresh request.
        grant_mask = grant_fire ? (ONE_REQ << win_id) : '0;
        pending_d  = (pending_q & ~grant_mask) | REQ_IN;
    end

`ifdef FLAG_ARB_LOST_CNT_EN
    logic [7:0]       lost_cnt_q, lost_cnt_d;
    logic [N_REQ-1:0] lost_bits;
    logic [4:0]       lost_add;
    logic [8:0]       lost_sum;

    always_comb begin
        lost_bits = REQ_IN & pending_q & ~grant_mask;
        lost_add  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            lost_add = lost_add + {4'b0, lost_bits[k]};
        end
        lost_sum = {1'b0, lost_cnt_q} + {4'b0, lost_add};
        if (ERR_CLR) begin
            lost_cnt_d = '0;
        end else if (lost_sum > 9'd255) begin
            lost_cnt_d = 8'hFF;
        end else begin
            lost_cnt_d = lost_sum[7:0];
        end
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            lost_cnt_q <= '0;
        end else begin
            lost_cnt_q <= lost_cnt_d;
        end
    end

    assign LOST_CNT = lost_cnt_q;
`endif

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            last_grant_q <= LAST_IDX;   // index 0 searched first after reset
            flag_out_q   <= 1'b0;
            grant_id_q   <= '0;
            busy_out_q   <= 1'b0;
            done_q       <= 1'b0;
            done_id_q    <= '0;
            error_q      <= 1'b0;
            rise_cnt_q   <= 1'b0;
            fall_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            last_grant_q <= last_grant_d;
            flag_out_q   <= flag_out_d;
            grant_id_q   <= grant_id_d;
            busy_out_q   <= busy_out_d;
            done_q       <= done_d;
            done_id_q    <= done_id_d;
            error_q      <= error_d;
            rise_cnt_q   <= rise_cnt_d;
            fall_cnt_q   <= fall_cnt_d;
        end
    end

    assign FLAG_OUT  = flag_out_q;
    assign GRANT_ID  = grant_id_q;
    assign PENDING   = pending_q;
    assign BUSY_OUT  = busy_out_q;
    assign DONE      = done_q;
    assign DONE_ID   = done_id_q;
    assign ERROR     = error_q;
    assign DBG_STATE = state_q;

endmodule

// File: doc/flag_crossing_arbiter.md
Name: flag_crossing_arbiter

Overview:
- Shares one flag_ack_domain_crossing channel between N_REQ single-cycle request sources in the BUS_CLK domain.
- Latches each request as pending and grants pending sources round-robin. Issues exactly one FLAG_OUT pulse per grant.
- Sequences on the crossing's BUSY handshake, and reports completion and timeouts.
- Sits on the source side of the crossing: FLAG_OUT drives FLAG_IN_CLK_A, BUSY_IN is driven by BUSY_CLK_A.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- ID_WIDTH, 2, width of GRANT_ID/DONE_ID; must be at least clog2(N_REQ).
- TIMEOUT, 255, max BUS_CLK cycles in WAIT_FALL before abort (1..65535).

Ports:
- BUS_CLK  input  1  clock, single domain (equal to the crossing's CLK_A).
- BUS_RST  input  1  asynchronous, active-high reset.
- REQ_IN  input  N_REQ  one-cycle request pulses, one bit per source.
- ENABLE  input  1  when 0, no new grants; requests are still latched.
- BUSY_IN  input  1  BUSY from the crossing.
- ERR_CLR  input  1  clears ERROR.
- FLAG_OUT  output  1  one-cycle flag to the crossing.
- GRANT_ID  output  ID_WIDTH  source of the transfer in flight; valid while BUSY_OUT=1.
- PENDING  output  N_REQ  latched, not-yet-granted requests.
- BUSY_OUT  output  1  high in every state except IDLE.
- DONE  output  1  one-cycle pulse when a transfer has been acknowledged.
- DONE_ID  output  ID_WIDTH  source of the completed transfer; valid with DONE.
- ERROR  output  1  sticky error flag.

Behaviour:
- Reset (async): every output is 0; PENDING=0; FSM goes to IDLE; the round-robin pointer gives index 0 highest priority.
- Pending latch:
  - PENDING[i] is set on the edge that samples REQ_IN[i]=1.
  - PENDING[i] is cleared on the edge at which source i is granted.
  - If REQ_IN[i] arrives on the same edge as its own grant, the bit stays set; that is a new request.
  - A request on an already-set bit merges into it (it is lost; counted only with the optional feature).
- Arbitration: the winner is the first set PENDING bit at or after (last_grant+1) mod N_REQ, searching upward with wrap-around.
- FSM, all outputs registered:
  - IDLE: if ENABLE=1, PENDING≠0 and BUSY_IN=0, then on that edge FLAG_OUT<=1, GRANT_ID<=winner, clear the winner's bit, update the pointer, and go to WAIT_RISE. BUSY_OUT goes high on the same edge.
  - WAIT_RISE: FLAG_OUT<=0. If BUSY_IN=1, go to WAIT_FALL and clear the counter. If BUSY_IN is still 0 after 2 cycles in this state, set ERROR and go to IDLE with no DONE.
  - WAIT_FALL: the counter increments each cycle. If BUSY_IN=0, DONE<=1, DONE_ID<=GRANT_ID, go to IDLE. Else if counter=TIMEOUT, set ERROR and go to IDLE; the request is dropped and there is no DONE.
- Latency:
  - REQ_IN at edge k: PENDING visible after edge k, FLAG_OUT high after edge k+1 (if IDLE and not busy).
  - A back-to-back grant is possible on the edge after DONE.
- ERROR: set takes priority over ERR_CLR when both occur on the same edge. ERROR does not stop arbitration.
- ENABLE going low mid-transfer does not abort the transfer; it only blocks the next grant.
- Reset mid-transfer: all state clears immediately. The crossing may still be toggling; the first post-reset grant waits for BUSY_IN=0.

Optional Feature:
- Macro FLAG_ARB_LOST_CNT_EN.
- When defined: adds output LOST_CNT (8 bits), a saturating count of REQ_IN bits that arrive while their PENDING bit is already set and not being granted that edge.
  - Multiple lost bits on one edge add their popcount.
  - The count stops at 255.
  - Reset to 0; ERR_CLR also clears it.
- When not defined: no LOST_CNT port and no counter logic; merged requests are silently dropped.

Test Plan:
- Single request: REQ_IN=4'b0010 for 1 cycle, crossing model with BUSY high for 6 cycles -> FLAG_OUT pulses once 2 edges after the request, GRANT_ID=1, DONE pulses with DONE_ID=1 one cycle after BUSY_IN falls, PENDING returns to 0.
- Round-robin: REQ_IN=4'b1111 in one cycle -> grant order 0,1,2,3. Then REQ_IN=4'b0101 after the last grant=3 -> order 0,2.
- Merge and lost count: REQ_IN[2] pulsed 3 times while a transfer for source 0 is in flight -> source 2 granted once; LOST_CNT=2 with FLAG_ARB_LOST_CNT_EN.
- Same-edge re-request: REQ_IN[1] pulses on the grant edge of source 1 -> PENDING[1] stays 1 and a second grant to 1 follows.
- Timeouts:
  - BUSY_IN held high, TIMEOUT=10 -> ERROR=1 10 cycles after entering WAIT_FALL, no DONE, FSM back in IDLE.
  - BUSY_IN never rising -> ERROR after 2 cycles in WAIT_RISE.
  - ERR_CLR then clears ERROR.
- Gating and reset: ENABLE=0 with PENDING=4'b0011 -> no FLAG_OUT. BUS_RST pulsed mid-WAIT_FALL -> all outputs 0 immediately; after release with BUSY_IN=0, no grant until a new request.
